// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode constants used by the ID/EX decode and the
// controller, the controller state type, default latencies and the HI/LO
// payload type.
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Opcodes that start a multi-cycle operation (mult/multu/div/divu).
  function automatic logic is_launch_op(input logic [OP_W-1:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath.
// Ports:
//   op       in  MDU opcode (only 1-4 produce a result, others give 0)
//   a, b     in  rs / rt operands
//   res      out {hi,lo}: product for mult/multu, {remainder,quotient} for div/divu
//   div_zero out div/divu with b==0 (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output hilo_t           res,
  output logic            div_zero
);

  logic        mul_sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Multiply: the low 64 bits of a sign/zero-extended product give both forms.
  always_comb begin
    mul_sgn = (op == MDU_MULT);
    a_ext   = {{32{mul_sgn & a[31]}}, a};
    b_ext   = {{32{mul_sgn & b[31]}}, b};
    prod    = a_ext * b_ext;
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  always_comb begin
    a_neg = (op == MDU_DIV) & a[31];
    b_neg = (op == MDU_DIV) & b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;  // keeps the divider defined on /0
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Result select.
  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: res = prod;
      MDU_DIV, MDU_DIVU: begin
        res.hi   = rem;
        res.lo   = quo;
        div_zero = (b == 32'd0);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller in EX: owns HI/LO, runs mult/div with fixed latency,
// serves mfhi/mflo/mthi/mtlo and exports busy for the hazard unit.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   op          MDU opcode (9-15 behave as none)
//   a, b        forwarded rs / rt operands
//   cancel      EX instruction flushed; suppresses launch and HI/LO writes
//   start       comb: launch accepted this cycle
//   busy        reg: operation in flight
//   md_busy     comb: start | busy
//   rd          comb: HI for mfhi, LO for mflo, else 0
//   hi, lo      committed HI/LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            cancel,
  output logic            start,
  output logic            busy,
  output logic            md_busy,
  output logic [31:0]     rd,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  hilo_t            pend_q;
  logic             pend_wr_q;
  hilo_t            arith_res;
  logic             div_zero;
  logic             idle;
  logic             commit;
  logic             move_ok;

  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .res      (arith_res),
    .div_zero (div_zero)
  );

  // State register: FSM state, countdown and the registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == S_RUN);
    end
  end

  // Next-state: load the latency on launch, count down, leave RUN on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = (op == MDU_MULT || op == MDU_MULTU) ? CNT_W'(MULT_CYCLES)
                                                        : CNT_W'(DIV_CYCLES);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and internal strobes.
  always_comb begin
    idle    = (state_q == S_IDLE);
    start   = idle & is_launch_op(op) & ~cancel;
    md_busy = start | busy;
    commit  = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
    move_ok = idle & ~cancel;
    case (op)
      MDU_MFHI: rd = hi;
      MDU_MFLO: rd = lo;
      default:  rd = '0;
    endcase
  end

  // Pending result and HI/LO. Commit happens only in RUN and moves only in
  // IDLE, so the two never collide. Divide-by-zero completes without writing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (start) begin
        pend_q    <= arith_res;
        pend_wr_q <= ~div_zero;
      end
      if (commit && pend_wr_q) begin
        hi <= pend_q.hi;
        lo <= pend_q.lo;
      end else if (move_ok && op == MDU_MTHI) begin
        hi <= a;
      end else if (move_ok && op == MDU_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule
